// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and FSM encoding for the register-file write path
// (arbiter, register file and datapath all import this).
package regfile_write_arbiter_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 4;
   localparam int NUM_REGS_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: a lone request always wins, and on a tie
// the requester that was not granted most recently wins.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic favour_b;

   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || !favour_b)) begin
         grant = 2'b01;
      end else if (req[1]) begin
         grant = 2'b10;
      end
   end

   // After any grant, the tie-break goes to the other requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         favour_b <= 1'b0;
      end else if (grant[0]) begin
         favour_b <= 1'b1;
      end else if (grant[1]) begin
         favour_b <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: merges ALU writeback (A) and load return (B)
// onto one registered write port, with a zero-fill sweep over all registers.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              rf_enable,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   rf_state_e         state;
   rf_state_e         state_next;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_inc;
   logic              last_idx;
   logic              accept_en;
   logic [1:0]        grant;

   assign idx_inc   = idx + ADDR_W'(1);
   assign last_idx  = (idx == LAST_IDX);
   // A clear request in the same cycle blocks both requesters.
   assign accept_en = (state == IDLE) && !clear_start;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   ({b_valid, a_valid} & {2{accept_en}}),
      .grant (grant)
   );

   assign a_ready = grant[0];
   assign b_ready = grant[1];

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (clear_start) state_next = CLEAR;
         CLEAR:   if (last_idx)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // While in CLEAR the rf_* outputs carry the sweep write for idx, so the
   // sweep lasts exactly NUM_REGS cycles and never runs past LAST_IDX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx           <= '0;
         rf_enable     <= 1'b0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
         clear_busy    <= 1'b0;
         clear_done    <= 1'b0;
      end else begin
         rf_enable  <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
         if (state == IDLE) begin
            if (clear_start) begin
               idx           <= '0;
               rf_enable     <= 1'b1;
               rf_write_reg  <= '0;
               rf_write_data <= '0;
               clear_busy    <= 1'b1;
               clear_done    <= (LAST_IDX == '0);
            end else if (grant[0]) begin
               rf_enable     <= 1'b1;
               rf_write_reg  <= a_reg;
               rf_write_data <= a_data;
            end else if (grant[1]) begin
               rf_enable     <= 1'b1;
               rf_write_reg  <= b_reg;
               rf_write_data <= b_data;
            end
         end else if (!last_idx) begin
            idx           <= idx_inc;
            rf_enable     <= 1'b1;
            rf_write_reg  <= idx_inc;
            rf_write_data <= '0;
            clear_busy    <= 1'b1;
            clear_done    <= (idx_inc == LAST_IDX);
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus random traffic,
// checked against a queue-of-pending-writes reference model.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [3:0]  a_reg, b_reg;
   logic [15:0] a_data, b_data;
   logic        clear_start, clear_busy, clear_done;
   logic        rf_enable;
   logic [3:0]  rf_write_reg;
   logic [15:0] rf_write_data;

   typedef struct packed {
      logic        sweep;
      logic        done;
      logic [3:0]  r;
      logic [15:0] d;
   } ent_t;

   ent_t        q[$];
   bit          favourB;
   int          total;
   int          bad;
   int          sweepWrites;
   int          doneCount;
   logic [15:0] rfShadow[16];

   regfile_write_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .a_valid       (a_valid),
      .a_ready       (a_ready),
      .a_reg         (a_reg),
      .a_data        (a_data),
      .b_valid       (b_valid),
      .b_ready       (b_ready),
      .b_reg         (b_reg),
      .b_data        (b_data),
      .clear_start   (clear_start),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .rf_enable     (rf_enable),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input ent_t cur, input bit expEn, input bit expA, input bit expB);
      check("a_ready", 32'(a_ready), 32'(expA));
      check("b_ready", 32'(b_ready), 32'(expB));
      check("rf_enable", 32'(rf_enable), 32'(expEn));
      check("clear_busy", 32'(clear_busy), 32'(cur.sweep));
      check("clear_done", 32'(clear_done), 32'(cur.done));
      if (expEn) begin
         check("rf_write_reg", 32'(rf_write_reg), 32'(cur.r));
         check("rf_write_data", 32'(rf_write_data), 32'(cur.d));
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, then compare the DUT
   // against the model and schedule whatever the model accepts this cycle.
   task automatic applyStimulus(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                                input bit bv, input logic [3:0] br, input logic [15:0] bd,
                                input bit cs);
      ent_t cur;
      bit   expEn, expA, expB;
      @(negedge clk);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      clear_start = cs;
      #1;
      cur   = '0;
      expEn = 1'b0;
      expA  = 1'b0;
      expB  = 1'b0;
      if (q.size() > 0) begin
         cur   = q.pop_front();
         expEn = 1'b1;
      end
      if (!cur.sweep) begin
         if (cs) begin
            for (int i = 0; i < 16; i++) q.push_back('{1'b1, (i == 15), 4'(i), 16'h0});
         end else if (av && (!bv || !favourB)) begin
            expA = 1'b1;
            favourB = 1'b1;
            q.push_back('{1'b0, 1'b0, ar, ad});
         end else if (bv) begin
            expB = 1'b1;
            favourB = 1'b0;
            q.push_back('{1'b0, 1'b0, br, bd});
         end
      end
      checkOutput(cur, expEn, expA, expB);
      if (rf_enable) rfShadow[rf_write_reg] = rf_write_data;
      if (rf_enable && clear_busy) sweepWrites++;
      if (clear_done) doneCount++;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; clear_start = 1'b0;
      #1;
      check("rst_rf_enable", 32'(rf_enable), 32'd0);
      check("rst_clear_busy", 32'(clear_busy), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      q.delete();
      favourB = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; clear_start = 1'b0;
      a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
      for (int i = 0; i < 16; i++) rfShadow[i] = '0;

      // Single A write to reg 3
      resetDut();
      check("reset_rf_write_reg", 32'(rf_write_reg), 32'd0);
      check("reset_rf_write_data", 32'(rf_write_data), 32'd0);
      applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0);
      idleCycle();
      idleCycle();

      // Both requesters held for four cycles alternate A,B,A,B
      resetDut();
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 4'(i), 16'hA000 + 16'(i), 1'b1, 4'(8 + i), 16'hB000 + 16'(i), 1'b0);
      idleCycle();

      // Sweep with a concurrent A request, and a re-trigger at index 7
      resetDut();
      sweepWrites = 0; doneCount = 0;
      applyStimulus(1'b1, 4'd2, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b1);
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 4'd2, 16'h5555, 1'b0, 4'd0, 16'h0, (i == 7));
      applyStimulus(1'b1, 4'd2, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b0);
      idleCycle();
      check("sweep_write_count", 32'(sweepWrites), 32'd16);
      check("sweep_done_count", 32'(doneCount), 32'd1);

      // Reset in the middle of a sweep aborts it
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
      for (int i = 0; i < 5; i++) idleCycle();
      resetDut();
      for (int i = 0; i < 5; i++) idleCycle();

      // Same register from both sides: two writes, second grant wins
      resetDut();
      applyStimulus(1'b1, 4'd9, 16'hAAAA, 1'b1, 4'd9, 16'hBBBB, 1'b0);
      applyStimulus(1'b1, 4'd9, 16'hAAAA, 1'b1, 4'd9, 16'hBBBB, 1'b0);
      idleCycle();
      idleCycle();
      check("same_reg_final_value", 32'(rfShadow[9]), 32'hBBBB);

      // Random traffic with occasional sweep requests
      resetDut();
      for (int i = 0; i < 400; i++)
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                       1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                       ($urandom_range(0, 24) == 0));
      for (int i = 0; i < 18; i++) idleCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register index width.
REQ-003 SHALL have parameter NUM_REGS, default 16, registers swept by clear.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports a_valid/b_valid  input  1  requester A (ALU writeback) / B (load return) write request.
REQ-007 SHALL have ports a_ready/b_ready  output  1  grant; write accepted when valid && ready in the same cycle.
REQ-008 SHALL have ports a_reg/b_reg  input  ADDR_W  destination register index.
REQ-009 SHALL have ports a_data/b_data  input  DATA_W  write data.
REQ-010 SHALL have port clear_start  input  1  one-cycle pulse that starts the zero-fill sweep.
REQ-011 SHALL have port clear_busy  output  1  high while the sweep runs.
REQ-012 SHALL have port clear_done  output  1  one-cycle pulse on the final sweep write.
REQ-013 SHALL have ports rf_enable  output  1, rf_write_reg  output  ADDR_W, rf_write_data  output  DATA_W  register-file write port, all registered.

Function
REQ-014 SHALL implement an FSM with states IDLE and CLEAR.
REQ-015 In IDLE, a_ready/b_ready SHALL be combinational from valids, FSM state and the round-robin pointer; at most one is high per cycle.
REQ-016 If only one requester is valid in IDLE, that requester SHALL be granted.
REQ-017 If both are valid, the requester not granted most recently SHALL be granted; the pointer updates on every grant.
REQ-018 An accepted write SHALL appear on rf_enable/rf_write_reg/rf_write_data exactly one cycle later, for exactly one cycle.
REQ-019 rf_enable SHALL be low in any cycle that follows a cycle with no accepted write and no sweep write.
REQ-020 A clear_start seen in IDLE SHALL take priority over same-cycle requests: both readies low, the FSM enters CLEAR, and the sweep index is set to 0.
REQ-021 In CLEAR, both readies SHALL be low, and rf_enable SHALL be high with rf_write_data = 0 and rf_write_reg = index, one register per cycle for index 0..NUM_REGS-1.
REQ-022 clear_done SHALL pulse together with the index NUM_REGS-1 write; the FSM returns to IDLE on the following edge.
REQ-023 clear_start received while in CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-024 clear_busy SHALL be high exactly during the NUM_REGS cycles in which sweep writes are on the rf_* outputs.
REQ-025 Requests held valid during CLEAR SHALL be granted under REQ-016/017 in the first IDLE cycle.
REQ-026 Same register index from both requesters SHALL NOT be merged; each write issues separately, in grant order.
REQ-027 The sweep index counter SHALL be ADDR_W wide and SHALL NOT wrap past NUM_REGS-1.

Reset
REQ-028 rst SHALL asynchronously force: FSM=IDLE, pointer favouring A, index=0, rf_enable=0, rf_write_reg=0, rf_write_data=0, clear_busy=0, clear_done=0.
REQ-029 rst during CLEAR SHALL abort the sweep with no further rf writes; a write accepted in the reset cycle SHALL be dropped.

Structure
REQ-030 DATA_W, ADDR_W, NUM_REGS defaults and the FSM state encoding SHALL live in a shared package also used by the register file and datapath.
REQ-031 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (2 requests, grant vector, pointer update).

Verification
REQ-032 Only A valid, a_reg=3, a_data=0x1234 -> a_ready=1; next cycle rf_enable=1, rf_write_reg=3, rf_write_data=0x1234.
REQ-033 A and B held valid for 4 cycles after reset -> grants A,B,A,B; rf writes follow in the same order, each one cycle later.
REQ-034 clear_start with a_valid in the same cycle -> a_ready=0; 16 consecutive rf writes of 0 to regs 0..15; clear_done high with reg 15; a_ready=1 on the next cycle.
REQ-035 clear_start pulsed again at sweep index 7 -> sweep continues to 15, exactly 16 writes in total.
REQ-036 rst asserted at sweep index 5 -> rf_enable, clear_busy and clear_done go low immediately, with no writes after reset is released until a new request.
REQ-037 Both valid, both reg=9, A data 0xAAAA, B data 0xBBBB -> two writes to reg 9 in grant order; the final value is that of the second grant.
